mux21_rr_arb: RTL and testbench

- Two-requester round-robin arbiter that shares one 2:1 mux datapath (in1/in2 -> out) between two valid/ready sources.
- Generates the mux select, hands data through one registered output stage, and returns per-source ready.
- Sits in front of the mux21 datapath wherever two producers feed a single consumer.

---
 rtl/mux21_pkg.sv | 14 +
 rtl/mux21_rr_pick.sv | 14 +
 rtl/mux21_rr_arb.sv | 97 +++++++++
 tb/tb_mux21_rr_arb.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/mux21_pkg.sv
// Shared constants and types for the two-source round-robin mux arbiter.
// Source indices double as out_sel encodings; lock_e drives the packet-lock FSM.
package mux21_pkg;

    localparam logic SRC_IN1 = 1'b0;
    localparam logic SRC_IN2 = 1'b1;

    typedef enum logic [1:0] {
        ARB   = 2'd0,
        LOCK1 = 2'd1,
        LOCK2 = 2'd2
    } lock_e;

endpackage

// File: rtl/mux21_rr_pick.sv
// Combinational 2-way round-robin picker.
// Ports: valid[1:0] requests, ptr preferred source on a tie, grant[1:0] one-hot.
module mux21_rr_pick
    import mux21_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       ptr,
    output logic [1:0] grant
);

    assign grant[0] = valid[0] & (~valid[1] | (ptr == SRC_IN1));
    assign grant[1] = valid[1] & (~valid[0] | (ptr == SRC_IN2));

endmodule

// File: rtl/mux21_rr_arb.sv
// Two-source round-robin arbiter feeding one registered 2:1 mux output stage.
// Ports: clk, rst (sync, active high); inX_valid/inX_data/inX_ready per source;
// out_valid/out_data/out_sel/out_ready toward the consumer.
// MUX21_RR_ARB_LOCK_EN adds inX_last/out_last and holds the grant for a packet.
module mux21_rr_arb
    import mux21_pkg::*;
#(
    parameter int DW    = 8,
    parameter bit FIRST = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in1_valid,
    input  logic [DW-1:0] in1_data,
    output logic          in1_ready,
    input  logic          in2_valid,
    input  logic [DW-1:0] in2_data,
    output logic          in2_ready,
`ifdef MUX21_RR_ARB_LOCK_EN
    input  logic          in1_last,
    input  logic          in2_last,
    output logic          out_last,
`endif
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_sel,
    input  logic          out_ready
);

    logic       ptr;
    logic       load;
    logic       win;
    logic [1:0] req;
    logic [1:0] grant;

`ifdef MUX21_RR_ARB_LOCK_EN
    lock_e st;
    logic  win_last;

    // A locked packet masks the other source off entirely, idle or not.
    always_comb begin
        req = {in2_valid, in1_valid};
        if (st == LOCK1) req = {1'b0, in1_valid};
        if (st == LOCK2) req = {in2_valid, 1'b0};
    end

    assign win_last = win ? in2_last : in1_last;
`else
    assign req = {in2_valid, in1_valid};
`endif

    // Output register can take a beat when empty or draining this cycle.
    assign load = ~out_valid | out_ready;
    assign win  = grant[1];

    mux21_rr_pick u_pick (
        .valid (req),
        .ptr   (ptr),
        .grant (grant)
    );

    assign in1_ready = ~rst & load & grant[0];
    assign in2_ready = ~rst & load & grant[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sel   <= SRC_IN1;
            ptr       <= FIRST;
`ifdef MUX21_RR_ARB_LOCK_EN
            out_last  <= 1'b0;
            st        <= ARB;
`endif
        end else if (load) begin
            if (|grant) begin
                out_valid <= 1'b1;
                out_data  <= win ? in2_data : in1_data;
                out_sel   <= win;
`ifdef MUX21_RR_ARB_LOCK_EN
                out_last  <= win_last;
                if (win_last) begin
                    ptr <= ~win;
                    st  <= ARB;
                end else begin
                    st  <= win ? LOCK2 : LOCK1;
                end
`else
                ptr       <= ~win;
`endif
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux21_rr_arb.sv
// Bench for mux21_rr_arb: reference model of the arbitration rules plus
// directed vectors with literal expectations.
module tb_mux21_rr_arb;

    logic       clk;
    logic       rst;
    logic       in1_valid;
    logic [7:0] in1_data;
    logic       in1_ready;
    logic       in2_valid;
    logic [7:0] in2_data;
    logic       in2_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_sel;
    logic       out_ready;

    int total = 0;
    int bad   = 0;

    mux21_rr_arb #(.DW(8), .FIRST(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_ready (in1_ready),
        .in2_valid (in2_valid),
        .in2_data  (in2_data),
        .in2_ready (in2_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_sel   (out_sel),
        .out_ready (out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the output register as a slot, plus the last source served.
    // Ties go to the source not served last, or to FIRST after reset.
    initial begin
        bit       m_valid;
        bit [7:0] m_data;
        bit       m_sel;
        int       m_last;
        int       pref;
        int       w;
        bit       m_load;
        m_valid = 0;
        m_data  = 0;
        m_sel   = 0;
        m_last  = -1;
        forever begin
            @(negedge clk);
            m_load = !m_valid || out_ready;
            pref   = (m_last < 0) ? 0 : 1 - m_last;
            w      = -1;
            if (m_load && !rst) begin
                if (in1_valid && in2_valid) w = pref;
                else if (in1_valid) w = 0;
                else if (in2_valid) w = 1;
            end
            chk("m_rdy1", in1_ready, (w == 0));
            chk("m_rdy2", in2_ready, (w == 1));
            chk("m_ovalid", out_valid, m_valid);
            chk("m_odata", out_data, m_data);
            chk("m_osel", out_sel, m_sel);
            if (rst) begin
                m_valid = 0;
                m_data  = 0;
                m_sel   = 0;
                m_last  = -1;
            end else if (w >= 0) begin
                m_valid = 1;
                m_data  = (w == 1) ? in2_data : in1_data;
                m_sel   = (w == 1);
                m_last  = w;
            end else if (m_load) begin
                m_valid = 0;
            end
        end
    end

    task automatic drive(input bit r, input bit v1, input bit [7:0] d1,
                         input bit v2, input bit [7:0] d2, input bit ordy);
        @(posedge clk);
        #1;
        rst       = r;
        in1_valid = v1;
        in1_data  = d1;
        in2_valid = v2;
        in2_data  = d2;
        out_ready = ordy;
    endtask

    logic [2:0] vec [16];

    initial begin
        rst       = 1'b1;
        in1_valid = 1'b0;
        in1_data  = 8'h00;
        in2_valid = 1'b0;
        in2_data  = 8'h00;
        out_ready = 1'b1;

        // reset state
        @(negedge clk);
        chk("rst_ovalid", out_valid, 1'b0);
        chk("rst_odata", out_data, 8'h00);
        chk("rst_rdy1", in1_ready, 1'b0);

        // both valid: alternate in1, in2, in1
        drive(0, 1, 8'hA1, 1, 8'hB2, 1);
        @(negedge clk);
        chk("alt_rdy1", in1_ready, 1'b1);
        chk("alt_rdy2", in2_ready, 1'b0);
        @(negedge clk);
        chk("alt_d0", out_data, 8'hA1);
        chk("alt_s0", out_sel, 1'b0);
        @(negedge clk);
        chk("alt_d1", out_data, 8'hB2);
        chk("alt_s1", out_sel, 1'b1);
        @(negedge clk);
        chk("alt_d2", out_data, 8'hA1);
        chk("alt_s2", out_sel, 1'b0);

        // in2 alone (in2 also wins the tie on this same edge)
        @(posedge clk);
        #1;
        in1_valid = 1'b0;
        in2_data  = 8'h5C;
        @(negedge clk);
        chk("solo_rdy2", in2_ready, 1'b1);
        chk("solo_rdy1", in1_ready, 1'b0);
        @(negedge clk);
        chk("solo_ovalid", out_valid, 1'b1);
        chk("solo_odata", out_data, 8'h5C);
        chk("solo_osel", out_sel, 1'b1);

        // back-pressure for 3 cycles, then the other source goes next
        drive(0, 1, 8'hA1, 1, 8'hB2, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_odata", out_data, 8'h5C);
            chk("bp_rdy", {in1_ready, in2_ready}, 2'b00);
            if (i < 2) @(posedge clk);
        end
        drive(0, 1, 8'hA1, 1, 8'hB2, 1);
        @(negedge clk);
        chk("bp_rel_rdy1", in1_ready, 1'b1);
        @(negedge clk);
        chk("bp_rel_odata", out_data, 8'hA1);

        // reset mid-stream: no ready, register drops, restart from in1
        drive(1, 1, 8'hA1, 1, 8'hB2, 1);
        @(negedge clk);
        chk("mr_rdy", {in1_ready, in2_ready}, 2'b00);
        @(negedge clk);
        chk("mr_ovalid", out_valid, 1'b0);
        drive(0, 1, 8'hA1, 1, 8'hB2, 1);
        @(negedge clk);
        chk("mr_first", in1_ready, 1'b1);
        @(negedge clk);
        chk("mr_odata", out_data, 8'hA1);

        // idle: drains then out_valid drops
        drive(0, 0, 8'h00, 0, 8'h00, 1);
        @(negedge clk);
        chk("idle_ov1", out_valid, 1'b1);
        @(negedge clk);
        chk("idle_ov0", out_valid, 1'b0);

        // mixed vectors {v1, v2, out_ready}, checked by the model
        vec = '{3'b111, 3'b110, 3'b110, 3'b011, 3'b101, 3'b000,
                3'b111, 3'b001, 3'b100, 3'b111, 3'b010, 3'b011,
                3'b111, 3'b111, 3'b000, 3'b001};
        for (int i = 0; i < 16; i++) begin
            drive(0, vec[i][2], 8'(8'h10 + i), vec[i][1], 8'(8'h80 + i),
                  vec[i][0]);
        end
        drive(0, 0, 8'h00, 0, 8'h00, 1);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
